// File: rtl/ffe_coef_ctrl.sv
// ffe_coef_ctrl: shadow/active FFE coefficient banks with a
// symbol-aligned atomic commit and the symbol strobe generator.
module ffe_coef_ctrl #(
  parameter int COEF_BW   = 9,
  parameter int N_COEF    = 7,
  parameter int ADDR_BW   = 3,
  parameter int OS_FACTOR = 4,
  parameter logic signed [COEF_BW-1:0] CENTER_INIT = 9'sd128
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_run,
  output logic                      o_en,
  input  logic                      i_wr_valid,
  output logic                      o_wr_ready,
  input  logic [ADDR_BW-1:0]        i_wr_addr,
  input  logic [COEF_BW-1:0]        i_wr_data,
  input  logic                      i_commit,
  input  logic                      i_load_init,
  output logic                      o_commit_pend,
  output logic                      o_commit_done,
  output logic                      o_addr_err,
  output logic [COEF_BW*N_COEF-1:0] o_coefs
);

  localparam int CNT_BW = $clog2(OS_FACTOR);
  localparam logic [CNT_BW-1:0] CNT_MAX = CNT_BW'(OS_FACTOR - 1);
  localparam int CENTER = N_COEF / 2;

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_BW-1:0]  cnt;
  logic               en;
  logic               wr_ready;
  logic               wr_acc;
  logic               load;
  logic               swap;
  logic               addr_ok;
  logic               done;
  logic               aerr;
  logic [COEF_BW-1:0] shadow [N_COEF];
  logic [COEF_BW-1:0] active [N_COEF];

  function automatic logic [COEF_BW-1:0] init_val(input int i);
    return (i == CENTER) ? CENTER_INIT : '0;
  endfunction

  // Symbol divider; cnt parks at 0 while stopped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
      en  <= 1'b0;
    end else begin
      en <= i_run && (cnt == CNT_MAX);
      if (!i_run || cnt == CNT_MAX) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign addr_ok = ({1'b0, i_wr_addr} < (ADDR_BW + 1)'(N_COEF));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    wr_acc    = 1'b0;
    load      = 1'b0;
    swap      = 1'b0;
    unique case (state)
      IDLE: begin
        wr_ready = 1'b1;
        wr_acc   = i_wr_valid;
        load     = i_load_init;
        if (i_commit) begin
          state_nxt = PEND;
        end
      end
      PEND: begin
        // A stopped divider never strobes, so swap right away.
        if (en || !i_run) begin
          swap      = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_COEF; i++) begin
        shadow[i] <= init_val(i);
      end
    end else if (load) begin
      for (int i = 0; i < N_COEF; i++) begin
        shadow[i] <= init_val(i);
      end
    end else if (wr_acc && addr_ok) begin
      for (int i = 0; i < N_COEF; i++) begin
        if (i_wr_addr == ADDR_BW'(i)) begin
          shadow[i] <= i_wr_data;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_COEF; i++) begin
        active[i] <= init_val(i);
      end
    end else if (swap) begin
      for (int i = 0; i < N_COEF; i++) begin
        active[i] <= shadow[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      done <= 1'b0;
      aerr <= 1'b0;
    end else begin
      done <= swap;
      aerr <= wr_acc && !load && !addr_ok;
    end
  end

  always_comb begin
    o_coefs = '0;
    for (int i = 0; i < N_COEF; i++) begin
      o_coefs[i*COEF_BW +: COEF_BW] = active[i];
    end
  end

  assign o_en          = en;
  assign o_wr_ready    = wr_ready;
  assign o_commit_pend = (state == PEND);
  assign o_commit_done = done;
  assign o_addr_err    = aerr;

endmodule

// File: tb/tb_ffe_coef_ctrl.sv
// tb_ffe_coef_ctrl: directed plus random stimulus against a
// cycle-level behavioural model of the coefficient controller.
module tb_ffe_coef_ctrl;

  localparam int CW = 9;
  localparam int N  = 7;
  localparam int AW = 3;
  localparam int OS = 4;

  logic          clk;
  logic          rst;
  logic          run;
  logic          en;
  logic          wv;
  logic          wr_ready;
  logic [AW-1:0] addr;
  logic [CW-1:0] data;
  logic          commit;
  logic          load;
  logic          pend;
  logic          done;
  logic          aerr;
  logic [CW*N-1:0] coefs;

  ffe_coef_ctrl #(
    .COEF_BW(CW), .N_COEF(N), .ADDR_BW(AW), .OS_FACTOR(OS),
    .CENTER_INIT(9'sd128)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .o_en(en),
    .i_wr_valid(wv), .o_wr_ready(wr_ready),
    .i_wr_addr(addr), .i_wr_data(data),
    .i_commit(commit), .i_load_init(load),
    .o_commit_pend(pend), .o_commit_done(done),
    .o_addr_err(aerr), .o_coefs(coefs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference model, expressed in terms of the observable rules.
  logic [CW-1:0] m_sh  [N];
  logic [CW-1:0] m_act [N];
  bit m_pend;
  bit m_done;
  bit m_aerr;
  int m_streak;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] init_of(input int i);
    return (i == N / 2) ? 9'd128 : 9'd0;
  endfunction

  function automatic logic [CW*N-1:0] packed_act();
    logic [CW*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*CW +: CW] = m_act[i];
    return v;
  endfunction

  // en is high once every OS cycles of uninterrupted running.
  function automatic bit m_en();
    return (m_streak > 0) && (m_streak % OS == 0);
  endfunction

  task automatic step(input bit r, input bit rn, input bit v,
                      input int a, input int d, input bit c,
                      input bit l);
    bit en_now;
    rst = r; run = rn; wv = v;
    addr = AW'(a); data = CW'(d);
    commit = c; load = l;
    en_now = m_en();
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_sh[i] = init_of(i);
        m_act[i] = init_of(i);
      end
      m_pend = 0; m_done = 0; m_aerr = 0; m_streak = 0;
    end else begin
      m_done = 0; m_aerr = 0;
      if (!m_pend) begin
        if (l) begin
          for (int i = 0; i < N; i++) m_sh[i] = init_of(i);
        end else if (v) begin
          if (a < N) m_sh[a] = CW'(d);
          else m_aerr = 1;
        end
        if (c) m_pend = 1;
      end else if (en_now || !rn) begin
        for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
        m_pend = 0;
        m_done = 1;
      end
      m_streak = rn ? m_streak + 1 : 0;
    end
    @(posedge clk);
    #1;
    check("en", 64'(en), 64'(m_en()));
    check("wr_ready", 64'(wr_ready), 64'(!m_pend));
    check("pend", 64'(pend), 64'(m_pend));
    check("done", 64'(done), 64'(m_done));
    check("addr_err", 64'(aerr), 64'(m_aerr));
    check("coefs", 64'(coefs), 64'(packed_act()));
  endtask

  task automatic idle(input bit rn, input int k);
    for (int i = 0; i < k; i++) step(0, rn, 0, 0, 0, 0, 0);
  endtask

  int cyc;
  int en_cnt;

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1; run = 0; wv = 0; addr = '0; data = '0;
    commit = 0; load = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("rst_coefs", 64'(coefs), 64'(63'd128 << (3 * CW)));

    en_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0, 0, 0, 0);
      if (en) en_cnt++;
    end
    check("en_rate", 64'(en_cnt), 64'(16 / OS));

    // Write C0 = -5, C6 = 77, commit while running.
    step(0, 1, 1, 0, -5, 0, 0);
    step(0, 1, 1, 6, 77, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    cyc = 0;
    while (!done && cyc < 8) begin
      step(0, 1, 0, 0, 0, 0, 0);
      cyc++;
    end
    check("lat_run", 64'(cyc <= OS), 64'(1));
    check("c0", 64'(coefs[0 +: CW]), 64'(9'h1FB));
    check("c6", 64'(coefs[6*CW +: CW]), 64'(9'd77));

    // Held write to C2 during PEND lands after the swap.
    step(0, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 2, 33, 0, 0);
    idle(1, 2);

    // Write with commit; load_init with write.
    step(0, 1, 1, 1, 10, 1, 0);
    idle(1, 6);
    step(0, 1, 1, 1, 55, 0, 1);
    step(0, 1, 0, 0, 0, 1, 0);
    idle(1, 6);

    // Bad address, then commit.
    step(0, 1, 1, 7, 99, 0, 0);
    check("aerr_pulse", 64'(aerr), 64'(1));
    step(0, 1, 0, 0, 0, 1, 0);
    idle(1, 6);

    // Reset during PEND aborts the commit.
    step(0, 1, 1, 4, 3, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    check("rst_abort", 64'(coefs), 64'(63'd128 << (3 * CW)));
    idle(1, 3);

    // Commit with the divider stopped: done two cycles later.
    step(0, 0, 1, 5, -20, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("lat_stop", 64'(done), 64'(1));

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1),
           $urandom_range(0, 7),
           $urandom_range(0, 511),
           ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
